anc_lms_fir_mc: RTL

Multi-channel, parametrised adaptive LMS FIR engine for the ANC datapath. It time-multiplexes one multiply-accumulate pipeline across `CH` independent channels. Each channel keeps its own delay line and coefficient set. For each accepted sample the block computes one filter output and, optionally, one LMS coefficient update with optional leakage. The core drives samples in over a valid/ready handshake, and results return over a second valid/ready handshake with saturation.

---
 rtl/anc_lms_fir_mc.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/anc_lms_fir_mc.sv
// Multi-channel adaptive LMS FIR engine: one time-shared MAC pipeline,
// per-channel delay lines and coefficient banks, saturating result handshake.
//
// state | meaning
// IDLE  | waiting for a request or a coefficient clear
// RUN   | issuing one tap per cycle, idx = 0..TAPS-1
// DRAIN | flushing the multiply and accumulate stages (2 cycles)
// HOLD  | result presented until the consumer takes it
module anc_lms_fir_mc #(
  parameter int DW      = 16,
  parameter int CW      = 16,
  parameter int TAPS    = 128,
  parameter int CH      = 2,
  parameter int FRAC    = 15,
  parameter int LEAK_SH = 10,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1,
  localparam int TW     = $clog2(TAPS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  in_x,
  input  logic [DW-1:0]  in_mu_e,
  input  logic           adapt_en,
  input  logic           leak_en,
  input  logic           coef_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_y,
  output logic           busy
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + TW;
  localparam int MW = 2 * DW;
  localparam int UW = CW + 2;

  localparam logic signed [UW-1:0] W_HI = {{(UW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [UW-1:0] W_LO = {{(UW-CW+1){1'b1}}, {(CW-1){1'b0}}};
  localparam logic signed [AW-1:0] Y_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t state, state_d;
  logic accept, issue, last, done, clr;

  logic signed [CW-1:0] coef [CH][TAPS];
  logic signed [DW-1:0] xd   [CH][TAPS];

  logic [TW-1:0]        idx;
  logic [CHW-1:0]       ch_q;
  logic signed [DW-1:0] mu_q;
  logic                 adapt_q, leak_q;
  logic                 drain_cnt;

  logic signed [CW-1:0] w_rd;
  logic signed [DW-1:0] x_rd;
  logic signed [PW-1:0] prod;
  logic signed [MW-1:0] mu_x;
  logic signed [UW-1:0] d_upd;

  logic                 s1_v, s1_wr;
  logic [TW-1:0]        s1_idx;
  logic signed [PW-1:0] p_q;
  logic signed [UW-1:0] d_q;
  logic signed [CW-1:0] w_q;

  logic signed [UW-1:0] leak_term, w_sum;
  logic signed [CW-1:0] w_new;

  logic signed [AW-1:0] acc, acc_sh;
  logic signed [DW-1:0] y_sat;

  assign in_ready = (state == IDLE) && !coef_clr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    issue   = 1'b0;
    last    = 1'b0;
    done    = 1'b0;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (coef_clr) begin
          clr = 1'b1;
        end else if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (idx == TW'(TAPS - 1)) begin
          last    = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == 1'b0) begin
          done    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: taps are read from the already-shifted delay line.
  always_comb begin
    w_rd  = coef[ch_q][idx];
    x_rd  = xd[ch_q][idx];
    prod  = PW'(w_rd) * PW'(x_rd);
    mu_x  = MW'(mu_q) * MW'(x_rd);
    d_upd = UW'(mu_x >>> FRAC);
  end

  always_comb begin
    leak_term = leak_q ? UW'(w_q >>> LEAK_SH) : '0;
    w_sum     = UW'(w_q) + d_q - leak_term;
    if (w_sum > W_HI)      w_new = W_HI[CW-1:0];
    else if (w_sum < W_LO) w_new = W_LO[CW-1:0];
    else                   w_new = w_sum[CW-1:0];
  end

  always_comb begin
    acc_sh = acc >>> FRAC;
    if (acc_sh > Y_HI)      y_sat = Y_HI[DW-1:0];
    else if (acc_sh < Y_LO) y_sat = Y_LO[DW-1:0];
    else                    y_sat = acc_sh[DW-1:0];
  end

  // Coefficient banks and delay lines; write-back lands one edge after the
  // product is registered, before any later request can read that tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          coef[c][k] <= '0;
          xd[c][k]   <= '0;
        end
      end
    end else if (clr) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          coef[c][k] <= '0;
          xd[c][k]   <= '0;
        end
      end
    end else begin
      if (accept) begin
        xd[in_ch][0] <= in_x;
        for (int k = 1; k < TAPS; k++) xd[in_ch][k] <= xd[in_ch][k-1];
      end
      if (s1_wr) coef[ch_q][s1_idx] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      ch_q      <= '0;
      mu_q      <= '0;
      adapt_q   <= 1'b0;
      leak_q    <= 1'b0;
      drain_cnt <= 1'b0;
      s1_v      <= 1'b0;
      s1_wr     <= 1'b0;
      s1_idx    <= '0;
      p_q       <= '0;
      d_q       <= '0;
      w_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_y     <= '0;
    end else begin
      if (accept) begin
        ch_q    <= in_ch;
        mu_q    <= in_mu_e;
        adapt_q <= adapt_en;
        leak_q  <= leak_en;
        idx     <= '0;
        acc     <= '0;
      end
      if (issue) idx <= idx + TW'(1);

      if (last)                                drain_cnt <= 1'b1;
      else if (state == DRAIN && drain_cnt != 1'b0) drain_cnt <= drain_cnt - 1'b1;

      s1_v   <= issue;
      s1_wr  <= issue && adapt_q;
      s1_idx <= idx;
      p_q    <= prod;
      d_q    <= d_upd;
      w_q    <= w_rd;

      if (s1_v) acc <= acc + AW'(p_q);

      if (done) begin
        out_valid <= 1'b1;
        out_ch    <= ch_q;
        out_y     <= y_sat;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
